// File: rtl/fx_match_pkg.sv
// Shared types and constants for the fixed-point format-match arbiter.
// Holds word widths, requester count, the runtime config record and its reset value.
// No logic here; imported by the arbiter top and the quantize/overflow datapath.
package fx_match_pkg;

    localparam int N_REQ = 4;   // requesters sharing the converter
    localparam int IW    = 12;  // signed input word width
    localparam int OW    = 10;  // signed output word width
    localparam int TAG_W = 2;   // clog2(N_REQ)

    typedef enum logic {
        TRUNC = 1'b0,           // floor
        RHU   = 1'b1            // round half up
    } round_e;

    typedef enum logic {
        WRAP = 1'b0,
        SAT  = 1'b1
    } ovf_e;

    typedef struct packed {
        logic [1:0] shift;      // LSBs dropped, 0..3
        round_e     round;
        ovf_e       sat;
    } cfg_t;

    localparam cfg_t CFG_RST = '{shift: 2'd0, round: TRUNC, sat: SAT};

endpackage

// File: rtl/fx_quant_sat.sv
// Combinational quantize (drop LSBs, truncate or round-half-up) and overflow (saturate or wrap).
// Latency: none; the caller registers q between the two halves to form the S1/S2 pipeline.
// Backpressure: not applicable, pure function of its inputs.
// Ports: din/cfg -> q (S1 quantize, IW+1 bits signed); q_in/cfg.sat -> dout/ovf (S2 overflow).
module fx_quant_sat
    import fx_match_pkg::*;
(
    input  logic [IW-1:0] din,
    input  cfg_t          cfg,
    output logic [IW:0]   q,
    input  logic [IW:0]   q_in,
    output logic [OW-1:0] dout,
    output logic          ovf
);

    logic signed [IW:0] ext;
    logic signed [IW:0] shifted;
    logic               rnd_bit;

    always_comb begin
        ext     = {din[IW-1], din};
        shifted = ext >>> cfg.shift;
        // Adding the highest dropped bit turns the floor into round-half-up.
        rnd_bit = 1'b0;
        if (cfg.round == RHU) begin
            case (cfg.shift)
                2'd1:    rnd_bit = din[0];
                2'd2:    rnd_bit = din[1];
                2'd3:    rnd_bit = din[2];
                default: rnd_bit = 1'b0;
            endcase
        end
        q = shifted + {{IW{1'b0}}, rnd_bit};
    end

    generate
        if (OW >= IW + 1) begin : g_fit
            // Every quantized value is representable: plain sign extension.
            assign dout = OW'($signed(q_in));
            assign ovf  = 1'b0;
        end else begin : g_chk
            localparam logic [OW-1:0] O_MAX = {1'b0, {(OW-1){1'b1}}};
            localparam logic [OW-1:0] O_MIN = {1'b1, {(OW-1){1'b0}}};
            logic in_range;

            // In range exactly when the bits above the output sign bit all copy it.
            assign in_range = (&q_in[IW:OW-1]) | ~(|q_in[IW:OW-1]);

            always_comb begin
                dout = q_in[OW-1:0];
                ovf  = ~in_range;
                if (!in_range && cfg.sat == SAT) begin
                    dout = q_in[IW] ? O_MIN : O_MAX;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/fx_match_arbiter.sv
// Round-robin shares one two-stage fixed-point format-match pipeline among N_REQ requesters.
// Latency 2 cycles from accept to o_valid; 1 result per cycle while o_ready is high.
// Backpressure: o_ready low stalls S2 then S1; req_ready drops once both stages hold data.
// Ports: req_valid/req_data/req_ready per requester; o_valid/o_ready/o_data/o_tag/o_ovf result;
//        cfg_we/cfg_shift/cfg_round/cfg_sat runtime config (taken only when idle); busy.
module fx_match_arbiter
    import fx_match_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ*IW-1:0]   req_data,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  o_valid,
    input  logic                  o_ready,
    output logic [OW-1:0]         o_data,
    output logic [TAG_W-1:0]      o_tag,
    output logic                  o_ovf,
    input  logic                  cfg_we,
    input  logic [1:0]            cfg_shift,
    input  logic                  cfg_round,
    input  logic                  cfg_sat,
    output logic                  busy
);

    cfg_t             cfg;
    logic [TAG_W-1:0] ptr;

    logic             s1_valid;
    logic [IW:0]      s1_q;
    logic [TAG_W-1:0] s1_tag;
    logic             s2_valid;

    logic             adv1;
    logic             adv2;
    logic             cfg_take;
    logic             grant_en;
    logic             grant_any;
    logic [TAG_W-1:0] grant_idx;
    logic [TAG_W-1:0] rr_idx;
    logic [IW-1:0]    grant_data;
    logic [IW:0]      q_new;
    logic [OW-1:0]    res_data;
    logic             res_ovf;

    assign o_valid  = s2_valid;
    assign adv2     = ~s2_valid | o_ready;
    assign adv1     = ~s1_valid | adv2;
    assign busy     = s1_valid | s2_valid;
    // Config may only change with the pipeline empty so both stages see one config.
    assign cfg_take = cfg_we & ~busy;
    assign grant_en = adv1 & ~cfg_take & ~rst;

    // First valid requester at or after ptr, wrapping.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = ptr;
        rr_idx    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            rr_idx = TAG_W'((int'(ptr) + k) % N_REQ);
            if (!grant_any && req_valid[rr_idx]) begin
                grant_any = 1'b1;
                grant_idx = rr_idx;
            end
        end
    end

    assign req_ready  = (grant_en && grant_any) ? (N_REQ'(1) << grant_idx) : '0;
    assign grant_data = req_data[grant_idx*IW +: IW];

    fx_quant_sat u_quant_sat (
        .din  (grant_data),
        .cfg  (cfg),
        .q    (q_new),
        .q_in (s1_q),
        .dout (res_data),
        .ovf  (res_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg      <= CFG_RST;
            ptr      <= '0;
            s1_valid <= 1'b0;
            s1_q     <= '0;
            s1_tag   <= '0;
            s2_valid <= 1'b0;
            o_data   <= '0;
            o_tag    <= '0;
            o_ovf    <= 1'b0;
        end else begin
            if (cfg_take) begin
                cfg <= '{shift: cfg_shift, round: round_e'(cfg_round), sat: ovf_e'(cfg_sat)};
            end
            if (grant_en && grant_any) begin
                ptr <= TAG_W'((int'(grant_idx) + 1) % N_REQ);
            end
            if (adv1) begin
                s1_valid <= grant_en & grant_any;
                if (grant_en && grant_any) begin
                    s1_q   <= q_new;
                    s1_tag <= grant_idx;
                end
            end
            // Output registers only load on a real word, so they hold while stalled.
            if (adv2) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    o_data <= res_data;
                    o_tag  <= s1_tag;
                    o_ovf  <= res_ovf;
                end
            end
        end
    end

endmodule

// File: tb/tb_fx_match_arbiter.sv
module tb_fx_match_arbiter;
    import fx_match_pkg::*;

    logic                clk = 1'b0;
    logic                rst;
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ*IW-1:0] req_data;
    logic [N_REQ-1:0]    req_ready;
    logic                o_valid;
    logic                o_ready;
    logic [OW-1:0]       o_data;
    logic [TAG_W-1:0]    o_tag;
    logic                o_ovf;
    logic                cfg_we;
    logic [1:0]          cfg_shift;
    logic                cfg_round;
    logic                cfg_sat;
    logic                busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fx_match_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .o_valid   (o_valid),
        .o_ready   (o_ready),
        .o_data    (o_data),
        .o_tag     (o_tag),
        .o_ovf     (o_ovf),
        .cfg_we    (cfg_we),
        .cfg_shift (cfg_shift),
        .cfg_round (cfg_round),
        .cfg_sat   (cfg_sat),
        .busy      (busy)
    );

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct {
        int d;
        int tag;
        int ovf;
        int cyc;
    } exp_t;

    localparam int OMAX = (1 << (OW - 1)) - 1;
    localparam int OMIN = -(1 << (OW - 1));

    exp_t exp_q[$];
    int   ncyc    = 0;
    int   m_ptr   = 0;
    int   m_shift = 0;
    int   m_round = 0;
    int   m_sat   = 1;
    int   gi;
    int   g_exp;
    bit   vis;
    bit   take;
    bit   can;

    function automatic exp_t conv(input logic [IW-1:0] w, input int tag);
        exp_t e;
        int   v;
        int   qv;
        v = int'($signed(w));
        if (m_round != 0 && m_shift > 0) qv = (v + (1 << (m_shift - 1))) >>> m_shift;
        else                             qv = v >>> m_shift;
        e.tag = tag;
        e.cyc = ncyc;
        e.ovf = 0;
        e.d   = qv;
        if (qv > OMAX || qv < OMIN) begin
            e.ovf = 1;
            if (m_sat != 0) e.d = (qv > 0) ? OMAX : OMIN;
        end
        e.d = e.d & ((1 << OW) - 1);
        return e;
    endfunction

    // Predictions for the coming edge are made from inputs driven after the previous edge.
    always @(negedge clk) begin
        ncyc++;
        if (rst) begin
            exp_q.delete();
            m_ptr = 0; m_shift = 0; m_round = 0; m_sat = 1;
            check("rst_req_ready", int'(req_ready), 0);
            check("rst_o_valid", int'(o_valid), 0);
        end else begin
            // A word is visible once one edge has passed after the one that accepted it.
            vis  = (exp_q.size() > 0) && (exp_q[0].cyc + 2 <= ncyc);
            take = cfg_we && (exp_q.size() == 0);
            // At most two words in flight; a full pipeline only moves when the head leaves.
            can  = !take && ((exp_q.size() < 2) || (o_ready && vis));
            gi = -1;
            if (can) begin
                for (int k = 0; k < N_REQ; k++) begin
                    if (gi < 0 && req_valid[(m_ptr + k) % N_REQ]) gi = (m_ptr + k) % N_REQ;
                end
            end
            g_exp = (gi >= 0) ? (1 << gi) : 0;
            check("req_ready", int'(req_ready), g_exp);
            check("o_valid", int'(o_valid), int'(vis));
            check("busy", int'(busy), int'(exp_q.size() != 0));
            if (vis) begin
                check("o_data", int'(o_data), exp_q[0].d);
                check("o_tag", int'(o_tag), exp_q[0].tag);
                check("o_ovf", int'(o_ovf), exp_q[0].ovf);
            end
            if (vis && o_ready) void'(exp_q.pop_front());
            if (gi >= 0) begin
                exp_q.push_back(conv(req_data[gi*IW +: IW], gi));
                m_ptr = (gi + 1) % N_REQ;
            end
            if (take) begin
                m_shift = int'(cfg_shift);
                m_round = int'(cfg_round);
                m_sat   = int'(cfg_sat);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic single(input int r, input logic [IW-1:0] w, input int exp_d,
                          input int exp_ovf, input string nm);
        int n;
        @(posedge clk); #1;
        req_data = (N_REQ*IW)'({$urandom, $urandom});
        req_data[r*IW +: IW] = w;
        req_valid = N_REQ'(1 << r);
        @(posedge clk); #1;
        req_valid = '0;
        n = 1;
        while (!o_valid && n < 6) begin
            @(posedge clk); #1;
            n++;
        end
        check({nm, "_lat"}, n, 2);
        check({nm, "_data"}, int'(o_data), exp_d);
        check({nm, "_ovf"}, int'(o_ovf), exp_ovf);
        check({nm, "_tag"}, int'(o_tag), r);
    endtask

    task automatic cfg_write(input int sh, input int rnd, input int sat);
        @(posedge clk); #1;
        cfg_we = 1'b1;
        cfg_shift = sh[1:0];
        cfg_round = rnd[0];
        cfg_sat = sat[0];
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    int            n;
    int            acc;
    bit            held;
    logic [OW-1:0] hd;
    logic [TAG_W-1:0] ht;

    initial begin
        rst = 1'b1; req_valid = '0; req_data = '0; o_ready = 1'b1;
        cfg_we = 1'b0; cfg_shift = '0; cfg_round = 1'b0; cfg_sat = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_o_valid", int'(o_valid), 0);
        check("reset_req_ready", int'(req_ready), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_o_data", int'(o_data), 0);
        check("reset_o_tag", int'(o_tag), 0);
        check("reset_o_ovf", int'(o_ovf), 0);
        rst = 1'b0;

        // Default config: shift 0, truncate, saturate.
        single(0, 12'h1FF, 'h1FF, 0, "def_1ff");
        single(0, 12'h400, 'h1FF, 1, "def_pos_sat");
        single(0, 12'hC00, 'h200, 1, "def_neg_sat");

        cfg_write(2, 1, 1);
        single(0, 12'h007, 'h002, 0, "rhu_007");
        single(0, 12'hFF9, 'h3FE, 0, "rhu_ff9");
        single(0, 12'hFFA, 'h3FF, 0, "rhu_ffa");
        cfg_write(2, 0, 1);
        single(0, 12'h007, 'h001, 0, "trunc_007");

        cfg_write(0, 0, 0);
        single(0, 12'h400, 'h000, 1, "wrap_400");
        single(0, 12'h1FF, 'h1FF, 0, "wrap_1ff");

        // Config write taken while a request waits: that cycle grants nothing.
        @(posedge clk); #1;
        req_data[IW +: IW] = 12'h0F0;
        req_valid = 4'b0010;
        cfg_we = 1'b1; cfg_shift = 2'd1; cfg_round = 1'b0; cfg_sat = 1'b1;
        #3;
        check("cfg_take_no_grant", int'(req_ready), 0);
        @(posedge clk); #1;
        cfg_we = 1'b0;
        #3;
        check("cfg_next_grant", int'(req_ready), 'b0010);
        @(posedge clk); #1;
        req_valid = '0;
        n = 1;
        while (!o_valid && n < 6) begin
            @(posedge clk); #1;
            n++;
        end
        check("cfg_new_data", int'(o_data), 'h078);

        // Backpressure: five stalled cycles with everyone requesting.
        @(posedge clk); #1;
        req_valid = 4'hF;
        req_data = (N_REQ*IW)'({$urandom, $urandom});
        o_ready = 1'b0;
        acc = 0;
        held = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cfg_we = (i == 3); cfg_shift = 2'd3; cfg_round = 1'b1; cfg_sat = 1'b0;
            #3;
            if (req_ready != '0) acc++;
            if (o_valid) begin
                if (!held) begin
                    hd = o_data; ht = o_tag; held = 1'b1;
                end else begin
                    check("stall_hold_data", int'(o_data), int'(hd));
                    check("stall_hold_tag", int'(o_tag), int'(ht));
                end
            end
            @(posedge clk); #1;
        end
        cfg_we = 1'b0;
        check("stall_accepts", acc, 2);
        o_ready = 1'b1;
        repeat (8) begin
            req_data = (N_REQ*IW)'({$urandom, $urandom});
            @(posedge clk); #1;
        end
        req_valid = '0;
        repeat (4) @(posedge clk);
        #1;

        // Reset with two words in flight after a non-default config.
        cfg_write(1, 1, 0);
        @(posedge clk); #1;
        req_valid = 4'hF;
        req_data = (N_REQ*IW)'({$urandom, $urandom});
        o_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_rst_busy", int'(busy), 1);
        rst = 1'b1;
        #1;
        check("rst_async_o_valid", int'(o_valid), 0);
        check("rst_async_busy", int'(busy), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        o_ready = 1'b1;
        req_data[0 +: IW] = 12'h400;
        for (int k = 0; k < 6; k++) begin
            #3;
            check("rr_grant", int'(req_ready), 1 << (k % 4));
            if (k >= 2) begin
                check("rr_o_valid", int'(o_valid), 1);
                check("rr_o_tag", int'(o_tag), (k - 2) % 4);
                if (o_tag == 0) begin
                    check("rr_req0_data", int'(o_data), 'h1FF);
                    check("rr_req0_ovf", int'(o_ovf), 1);
                end
            end
            @(posedge clk); #1;
        end

        // Randomised traffic, stalls and config writes.
        for (int i = 0; i < 3000; i++) begin
            req_valid = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
            req_data  = (N_REQ*IW)'({$urandom, $urandom});
            o_ready   = ($urandom_range(0, 3) != 0);
            cfg_we    = ($urandom_range(0, 19) == 0);
            cfg_shift = 2'($urandom);
            cfg_round = 1'($urandom);
            cfg_sat   = 1'($urandom);
            @(posedge clk); #1;
        end

        req_valid = '0;
        cfg_we = 1'b0;
        o_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("drain_busy", int'(busy), 0);
        check("drain_model_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
